// File: rtl/pcileech_cfgspace_arbiter.sv
// Arbiter for the shadow config-space BRAM: one write port and one read port shared by
// TLP, USB and internal requesters, with starvation-based fairness and tagged read returns.
module pcileech_cfgspace_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int RD_LAT       = 2
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        tlp_req,
   input  logic        tlp_we,
   input  logic [9:0]  tlp_addr,
   input  logic [3:0]  tlp_be,
   input  logic [31:0] tlp_data,
   input  logic [7:0]  tlp_tag,
   output logic        tlp_gnt,
   output logic        tlp_rsp_valid,
   output logic [31:0] tlp_rsp_data,
   output logic [7:0]  tlp_rsp_tag,
   output logic [9:0]  tlp_rsp_addr,
   output logic        tlp_wack,
   output logic [7:0]  tlp_wack_tag,

   input  logic        usb_req,
   input  logic        usb_we,
   input  logic [9:0]  usb_addr,
   input  logic [3:0]  usb_be,
   input  logic [31:0] usb_data,
   input  logic [7:0]  usb_tag,
   output logic        usb_gnt,
   output logic        usb_rsp_valid,
   output logic [31:0] usb_rsp_data,
   output logic [7:0]  usb_rsp_tag,
   output logic [9:0]  usb_rsp_addr,

   input  logic        int_req,
   input  logic        int_we,
   input  logic [9:0]  int_addr,
   input  logic [3:0]  int_be,
   input  logic [31:0] int_data,
   input  logic [7:0]  int_tag,
   output logic        int_gnt,
   output logic        int_rsp_valid,
   output logic [31:0] int_rsp_data,
   output logic [7:0]  int_rsp_tag,
   output logic [9:0]  int_rsp_addr,

   input  logic        cfg_tlp_wren,
   input  logic        cfg_zero,

   output logic [3:0]  bram_wea,
   output logic [9:0]  bram_addra,
   output logic [31:0] bram_dina,
   output logic [9:0]  bram_addrb,
   input  logic [31:0] bram_doutb
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {SRC_NONE, SRC_TLP, SRC_USB, SRC_INT} src_t;

   typedef struct packed {
      logic       valid;
      src_t       src;
      logic [7:0] tag;
      logic [9:0] addr;
   } rd_ent_t;

   logic tlp_wc, usb_wc, int_wc, tlp_rc, usb_rc, int_rc;
   logic [3:0] usb_wcnt, int_wcnt, usb_rcnt, int_rcnt;
   logic rr_w, rr_r;
   src_t wr_win, rd_pick, rd_win;
   logic [9:0]  wr_addr, rd_addr, addrb_q;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic [7:0]  rd_tag;
   rd_ent_t [RD_LAT-1:0] pipe;
   rd_ent_t last;
   logic tlp_hit, usb_hit, int_hit;

   // Gating with rst_n keeps every grant and the write strobe low while in reset.
   assign tlp_wc = rst_n & tlp_req &  tlp_we;
   assign usb_wc = rst_n & usb_req &  usb_we;
   assign int_wc = rst_n & int_req &  int_we;
   assign tlp_rc = rst_n & tlp_req & ~tlp_we;
   assign usb_rc = rst_n & usb_req & ~usb_we;
   assign int_rc = rst_n & int_req & ~int_we;

   // Starving USB/INT beats TLP; rr = 0 prefers USB, rr = 1 prefers INT.
   function automatic src_t pick(input logic t, input logic u, input logic i,
                                 input logic us, input logic is, input logic rr);
      if (us && is) return rr ? SRC_INT : SRC_USB;
      if (us)       return SRC_USB;
      if (is)       return SRC_INT;
      if (t)        return SRC_TLP;
      if (u && i)   return rr ? SRC_INT : SRC_USB;
      if (u)        return SRC_USB;
      if (i)        return SRC_INT;
      return SRC_NONE;
   endfunction

   function automatic logic [3:0] next_cnt(input logic cand, input logic won,
                                           input logic [3:0] cnt);
      if (!cand || won) return 4'd0;
      if (cnt == LIMIT) return cnt;
      return cnt + 4'd1;
   endfunction

   always_comb begin
      wr_win  = pick(tlp_wc, usb_wc, int_wc,
                     usb_wc && (usb_wcnt == LIMIT), int_wc && (int_wcnt == LIMIT), rr_w);
      rd_pick = pick(tlp_rc, usb_rc, int_rc,
                     usb_rc && (usb_rcnt == LIMIT), int_rc && (int_rcnt == LIMIT), rr_r);
      wr_addr = '0;
      wr_be   = '0;
      wr_data = '0;
      case (wr_win)
         SRC_TLP: begin
            wr_addr = tlp_addr;
            wr_be   = cfg_tlp_wren ? tlp_be : 4'h0;
            wr_data = tlp_data;
         end
         SRC_USB: begin
            wr_addr = usb_addr;
            wr_be   = usb_be;
            wr_data = usb_data;
         end
         SRC_INT: begin
            wr_addr = int_addr;
            wr_be   = int_be;
            wr_data = int_data;
         end
         default: ;
      endcase
      rd_addr = '0;
      rd_tag  = '0;
      case (rd_pick)
         SRC_TLP: begin rd_addr = tlp_addr; rd_tag = tlp_tag; end
         SRC_USB: begin rd_addr = usb_addr; rd_tag = usb_tag; end
         SRC_INT: begin rd_addr = int_addr; rd_tag = int_tag; end
         default: ;
      endcase
      // A read colliding with this cycle's write retries, so it always sees the new data.
      rd_win = rd_pick;
      if (wr_win != SRC_NONE && rd_pick != SRC_NONE && rd_addr == wr_addr)
         rd_win = SRC_NONE;
   end

   assign tlp_gnt = (wr_win == SRC_TLP) || (rd_win == SRC_TLP);
   assign usb_gnt = (wr_win == SRC_USB) || (rd_win == SRC_USB);
   assign int_gnt = (wr_win == SRC_INT) || (rd_win == SRC_INT);

   assign bram_wea   = wr_be;
   assign bram_addra = wr_addr;
   assign bram_dina  = wr_data;
   assign bram_addrb = (rd_win != SRC_NONE) ? rd_addr : addrb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         usb_wcnt     <= '0;
         int_wcnt     <= '0;
         usb_rcnt     <= '0;
         int_rcnt     <= '0;
         rr_w         <= 1'b0;
         rr_r         <= 1'b0;
         addrb_q      <= '0;
         tlp_wack     <= 1'b0;
         tlp_wack_tag <= '0;
         pipe         <= '0;
      end else begin
         usb_wcnt <= next_cnt(usb_wc, wr_win == SRC_USB, usb_wcnt);
         int_wcnt <= next_cnt(int_wc, wr_win == SRC_INT, int_wcnt);
         usb_rcnt <= next_cnt(usb_rc, rd_win == SRC_USB, usb_rcnt);
         int_rcnt <= next_cnt(int_rc, rd_win == SRC_INT, int_rcnt);
         if (wr_win == SRC_USB)      rr_w <= 1'b1;
         else if (wr_win == SRC_INT) rr_w <= 1'b0;
         if (rd_win == SRC_USB)      rr_r <= 1'b1;
         else if (rd_win == SRC_INT) rr_r <= 1'b0;
         if (rd_win != SRC_NONE) addrb_q <= rd_addr;
         tlp_wack <= (wr_win == SRC_TLP);
         if (wr_win == SRC_TLP) tlp_wack_tag <= tlp_tag;
         pipe[0].valid <= (rd_win != SRC_NONE);
         pipe[0].src   <= rd_win;
         pipe[0].tag   <= rd_tag;
         pipe[0].addr  <= rd_addr;
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   // The last pipeline stage lines up with the BRAM output register.
   assign last    = pipe[RD_LAT-1];
   assign tlp_hit = last.valid && (last.src == SRC_TLP);
   assign usb_hit = last.valid && (last.src == SRC_USB);
   assign int_hit = last.valid && (last.src == SRC_INT);

   assign tlp_rsp_valid = tlp_hit;
   assign tlp_rsp_data  = (tlp_hit && !cfg_zero) ? bram_doutb : '0;
   assign tlp_rsp_tag   = tlp_hit ? last.tag  : '0;
   assign tlp_rsp_addr  = tlp_hit ? last.addr : '0;

   assign usb_rsp_valid = usb_hit;
   assign usb_rsp_data  = (usb_hit && !cfg_zero) ? bram_doutb : '0;
   assign usb_rsp_tag   = usb_hit ? last.tag  : '0;
   assign usb_rsp_addr  = usb_hit ? last.addr : '0;

   assign int_rsp_valid = int_hit;
   assign int_rsp_data  = (int_hit && !cfg_zero) ? bram_doutb : '0;
   assign int_rsp_tag   = int_hit ? last.tag  : '0;
   assign int_rsp_addr  = int_hit ? last.addr : '0;

endmodule

// File: tb/tb_pcileech_cfgspace_arbiter.sv
// Directed bench for pcileech_cfgspace_arbiter with a 2-cycle simple dual-port BRAM model.
module tb_pcileech_cfgspace_arbiter;

   localparam int S_TLP = 0;
   localparam int S_USB = 1;
   localparam int S_INT = 2;

   logic clk, rst_n;
   logic tlp_req, tlp_we, usb_req, usb_we, int_req, int_we;
   logic [9:0] tlp_addr, usb_addr, int_addr;
   logic [3:0] tlp_be, usb_be, int_be;
   logic [31:0] tlp_data, usb_data, int_data;
   logic [7:0] tlp_tag, usb_tag, int_tag;
   logic tlp_gnt, usb_gnt, int_gnt;
   logic tlp_rsp_valid, usb_rsp_valid, int_rsp_valid;
   logic [31:0] tlp_rsp_data, usb_rsp_data, int_rsp_data;
   logic [7:0] tlp_rsp_tag, usb_rsp_tag, int_rsp_tag;
   logic [9:0] tlp_rsp_addr, usb_rsp_addr, int_rsp_addr;
   logic tlp_wack;
   logic [7:0] tlp_wack_tag;
   logic cfg_tlp_wren, cfg_zero;
   logic [3:0] bram_wea;
   logic [9:0] bram_addra, bram_addrb;
   logic [31:0] bram_dina, bram_doutb;

   int total = 0;
   int bad = 0;

   pcileech_cfgspace_arbiter #(.STARVE_LIMIT(8), .RD_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .tlp_req(tlp_req), .tlp_we(tlp_we), .tlp_addr(tlp_addr), .tlp_be(tlp_be),
      .tlp_data(tlp_data), .tlp_tag(tlp_tag), .tlp_gnt(tlp_gnt),
      .tlp_rsp_valid(tlp_rsp_valid), .tlp_rsp_data(tlp_rsp_data),
      .tlp_rsp_tag(tlp_rsp_tag), .tlp_rsp_addr(tlp_rsp_addr),
      .tlp_wack(tlp_wack), .tlp_wack_tag(tlp_wack_tag),
      .usb_req(usb_req), .usb_we(usb_we), .usb_addr(usb_addr), .usb_be(usb_be),
      .usb_data(usb_data), .usb_tag(usb_tag), .usb_gnt(usb_gnt),
      .usb_rsp_valid(usb_rsp_valid), .usb_rsp_data(usb_rsp_data),
      .usb_rsp_tag(usb_rsp_tag), .usb_rsp_addr(usb_rsp_addr),
      .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_be(int_be),
      .int_data(int_data), .int_tag(int_tag), .int_gnt(int_gnt),
      .int_rsp_valid(int_rsp_valid), .int_rsp_data(int_rsp_data),
      .int_rsp_tag(int_rsp_tag), .int_rsp_addr(int_rsp_addr),
      .cfg_tlp_wren(cfg_tlp_wren), .cfg_zero(cfg_zero),
      .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
      .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: address sampled at one edge, data out of the output register one edge later.
   logic [31:0] mem [1024];
   logic [31:0] rd_q;
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (bram_wea[b]) mem[bram_addra][b*8 +: 8] <= bram_dina[b*8 +: 8];
      rd_q       <= mem[bram_addrb];
      bram_doutb <= rd_q;
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int src, input logic req, input logic we,
                                input logic [9:0] addr, input logic [3:0] be,
                                input logic [31:0] data, input logic [7:0] tag);
      case (src)
         S_TLP: begin tlp_req = req; tlp_we = we; tlp_addr = addr; tlp_be = be; tlp_data = data; tlp_tag = tag; end
         S_USB: begin usb_req = req; usb_we = we; usb_addr = addr; usb_be = be; usb_data = data; usb_tag = tag; end
         default: begin int_req = req; int_we = we; int_addr = addr; int_be = be; int_data = data; int_tag = tag; end
      endcase
   endtask

   function automatic logic getGnt(input int s);
      case (s)
         S_TLP:   return tlp_gnt;
         S_USB:   return usb_gnt;
         default: return int_gnt;
      endcase
   endfunction

   function automatic logic getRspValid(input int s);
      case (s)
         S_TLP:   return tlp_rsp_valid;
         S_USB:   return usb_rsp_valid;
         default: return int_rsp_valid;
      endcase
   endfunction

   function automatic logic [31:0] getRspData(input int s);
      case (s)
         S_TLP:   return tlp_rsp_data;
         S_USB:   return usb_rsp_data;
         default: return int_rsp_data;
      endcase
   endfunction

   function automatic logic [31:0] getRspTagAddr(input int s);
      case (s)
         S_TLP:   return {14'd0, tlp_rsp_addr, tlp_rsp_tag};
         S_USB:   return {14'd0, usb_rsp_addr, usb_rsp_tag};
         default: return {14'd0, int_rsp_addr, int_rsp_tag};
      endcase
   endfunction

   task automatic waitGnt(input int src, input string name);
      bit got = 0;
      for (int n = 0; n < 30 && !got; n++) begin
         @(negedge clk);
         if (getGnt(src)) got = 1;
         else tick();
      end
      checkOutput({name, " gnt"}, 32'(got), 32'd1);
   endtask

   task automatic doWrite(input int src, input logic [9:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input string name);
      applyStimulus(src, 1'b1, 1'b1, addr, be, data, 8'h00);
      waitGnt(src, name);
      tick();
      applyStimulus(src, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
   endtask

   task automatic doRead(input int src, input logic [9:0] addr, input logic [7:0] tag,
                         input logic [31:0] exp, input string name);
      applyStimulus(src, 1'b1, 1'b0, addr, 4'h0, 32'h0, tag);
      waitGnt(src, name);
      tick();
      applyStimulus(src, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      @(negedge clk);
      checkOutput({name, " early"}, 32'(getRspValid(src)), 32'd0);
      tick();
      @(negedge clk);
      checkOutput({name, " valid"}, 32'(getRspValid(src)), 32'd1);
      checkOutput({name, " data"}, getRspData(src), exp);
      checkOutput({name, " addr/tag"}, getRspTagAddr(src), {14'd0, addr, tag});
      tick();
      @(negedge clk);
      checkOutput({name, " late"}, 32'(getRspValid(src)), 32'd0);
      tick();
   endtask

   logic seen;

   initial begin
      rst_n = 1'b0;
      cfg_tlp_wren = 1'b1;
      cfg_zero = 1'b0;
      applyStimulus(S_TLP, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      applyStimulus(S_USB, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      applyStimulus(S_INT, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      tick();
      tick();

      // requests during reset must see no grant and no BRAM activity
      applyStimulus(S_USB, 1'b1, 1'b0, 10'h005, 4'h0, 32'h0, 8'h77);
      applyStimulus(S_TLP, 1'b1, 1'b1, 10'h006, 4'hF, 32'h1, 8'h00);
      @(negedge clk);
      checkOutput("reset gnt", 32'({tlp_gnt, usb_gnt, int_gnt}), 32'd0);
      checkOutput("reset wea", 32'(bram_wea), 32'd0);
      checkOutput("reset addrb", 32'(bram_addrb), 32'd0);
      checkOutput("reset rsp valid", 32'({tlp_rsp_valid, usb_rsp_valid, int_rsp_valid, tlp_wack}), 32'd0);
      checkOutput("reset rsp data", tlp_rsp_data | usb_rsp_data | int_rsp_data, 32'd0);
      tick();
      applyStimulus(S_USB, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      applyStimulus(S_TLP, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      rst_n = 1'b1;
      tick();

      // read accepted, then reset before its response emerges
      applyStimulus(S_USB, 1'b1, 1'b0, 10'h005, 4'h0, 32'h0, 8'h77);
      @(negedge clk);
      checkOutput("midrd gnt", 32'(usb_gnt), 32'd1);
      tick();
      applyStimulus(S_USB, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      rst_n = 1'b0;
      seen = 1'b0;
      @(negedge clk);
      seen = seen | usb_rsp_valid;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         seen = seen | tlp_rsp_valid | usb_rsp_valid | int_rsp_valid;
         tick();
      end
      checkOutput("midrd no rsp", 32'(seen), 32'd0);

      // basic write then read-back
      doWrite(S_USB, 10'h010, 4'hF, 32'hDEADBEEF, "basic wr");
      doRead(S_USB, 10'h010, 8'h01, 32'hDEADBEEF, "basic rd");

      // TLP vs USB reads: USB starves for 8 cycles then wins the 9th
      applyStimulus(S_TLP, 1'b1, 1'b0, 10'h100, 4'h0, 32'h0, 8'h10);
      applyStimulus(S_USB, 1'b1, 1'b0, 10'h101, 4'h0, 32'h0, 8'h11);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput($sformatf("prio cyc%0d", i), 32'({tlp_gnt, usb_gnt}),
                     (i % 9 == 8) ? 32'd1 : 32'd2);
         tick();
      end
      applyStimulus(S_TLP, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      applyStimulus(S_USB, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      tick();
      tick();
      tick();

      // same-address write/read in one cycle: read is held one cycle
      applyStimulus(S_INT, 1'b1, 1'b1, 10'h020, 4'hF, 32'h55AA55AA, 8'h00);
      applyStimulus(S_TLP, 1'b1, 1'b0, 10'h020, 4'h0, 32'h0, 8'h5A);
      @(negedge clk);
      checkOutput("haz int gnt", 32'(int_gnt), 32'd1);
      checkOutput("haz tlp held", 32'(tlp_gnt), 32'd0);
      tick();
      applyStimulus(S_INT, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      @(negedge clk);
      checkOutput("haz tlp gnt", 32'(tlp_gnt), 32'd1);
      tick();
      applyStimulus(S_TLP, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      tick();
      @(negedge clk);
      checkOutput("haz rsp valid", 32'(tlp_rsp_valid), 32'd1);
      checkOutput("haz rsp data", tlp_rsp_data, 32'h55AA55AA);
      checkOutput("haz rsp tag", 32'(tlp_rsp_tag), 32'h5A);
      tick();

      // masked TLP write is acked but leaves memory untouched
      doWrite(S_USB, 10'h030, 4'hF, 32'hCAFEF00D, "mask pre");
      cfg_tlp_wren = 1'b0;
      applyStimulus(S_TLP, 1'b1, 1'b1, 10'h030, 4'hF, 32'h12345678, 8'hC3);
      @(negedge clk);
      checkOutput("mask gnt", 32'(tlp_gnt), 32'd1);
      checkOutput("mask wea", 32'(bram_wea), 32'd0);
      checkOutput("mask wack early", 32'(tlp_wack), 32'd0);
      tick();
      applyStimulus(S_TLP, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      @(negedge clk);
      checkOutput("mask wack", 32'(tlp_wack), 32'd1);
      checkOutput("mask wack tag", 32'(tlp_wack_tag), 32'hC3);
      tick();
      @(negedge clk);
      checkOutput("mask wack end", 32'(tlp_wack), 32'd0);
      tick();
      cfg_tlp_wren = 1'b1;
      doRead(S_TLP, 10'h030, 8'h31, 32'hCAFEF00D, "mask rd");

      // cfg_zero blanks returned data
      cfg_zero = 1'b1;
      doRead(S_USB, 10'h010, 8'h02, 32'h0, "zero usb");
      doRead(S_INT, 10'h020, 8'h03, 32'h0, "zero int");
      cfg_zero = 1'b0;

      // USB/INT write round robin from a freshly reset pointer, plus partial byte enable
      doWrite(S_USB, 10'h050, 4'hF, 32'h11223344, "rr pre");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      applyStimulus(S_USB, 1'b1, 1'b1, 10'h050, 4'b0010, 32'hAABBCCDD, 8'h00);
      applyStimulus(S_INT, 1'b1, 1'b1, 10'h060, 4'hF, 32'h01020304, 8'h00);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rr cyc%0d", i), 32'({usb_gnt, int_gnt}),
                     (i % 2 == 0) ? 32'd2 : 32'd1);
         tick();
      end
      applyStimulus(S_USB, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      applyStimulus(S_INT, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 8'h00);
      doRead(S_USB, 10'h050, 8'h44, 32'h1122CC44, "be rd");
      doRead(S_INT, 10'h060, 8'h45, 32'h01020304, "rr int rd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
